// File: rtl/fnn_pkg.sv
// Shared state encoding, phase encoding and saturation limits for the FNN layer sequencer.
// Limits are expressed at the serial output width so they compare directly against layer output words.
package fnn_pkg;

  localparam int FNN_IN_W   = 26;
  localparam int FNN_DATA_W = FNN_IN_W + 3;

  localparam logic signed [FNN_DATA_W-1:0] SAT_MAX = FNN_DATA_W'((2 ** (FNN_IN_W - 1)) - 1);
  localparam logic signed [FNN_DATA_W-1:0] SAT_MIN = FNN_DATA_W'(-(2 ** (FNN_IN_W - 1)));

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_LOAD    = 4'd1;
  localparam logic [3:0] ST_LWAIT   = 4'd2;
  localparam logic [3:0] ST_READY   = 4'd3;
  localparam logic [3:0] ST_RUN1    = 4'd4;
  localparam logic [3:0] ST_XFER    = 4'd5;
  localparam logic [3:0] ST_RUN2    = 4'd6;
  localparam logic [3:0] ST_DRAIN   = 4'd7;
  localparam logic [3:0] ST_RESTART = 4'd8;

  // Sub-phases shared by XFER (SHIFT/CAPTURE) and DRAIN (SHIFT/CAPTURE/HOLD)
  localparam logic [1:0] PH_SHIFT   = 2'd0;
  localparam logic [1:0] PH_CAPTURE = 2'd1;
  localparam logic [1:0] PH_HOLD    = 2'd2;

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrowing of a layer-1 output word to the layer-2 input width.
// Purely combinational; no handshake.
module sat_narrow
  import fnn_pkg::*;
#(
  parameter int DATA_W = FNN_DATA_W,
  parameter int IN_W   = FNN_IN_W
) (
  input  logic [DATA_W-1:0] din,
  output logic [IN_W-1:0]   dout
);

  always_comb begin
    if ($signed(din) > SAT_MAX) begin
      dout = SAT_MAX[IN_W-1:0];
    end else if ($signed(din) < SAT_MIN) begin
      dout = SAT_MIN[IN_W-1:0];
    end else begin
      dout = din[IN_W-1:0];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences weight load, layer-1 run, saturating L1->L2 word transfer, layer-2 run and result drain.
// Outputs derive from posedge state; results wait in a held register until res_ready (unbounded stall).
module layer_sequencer
  import fnn_pkg::*;
#(
  parameter int NN1      = 30,
  parameter int NN2      = 10,
  parameter int IN_W     = FNN_IN_W,
  parameter int DATA_W   = IN_W + 3,
  parameter int WEIGHT_W = 16,
  parameter int PART_W   = 6
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [WEIGHT_W+PART_W-1:0] cfg_word,
  input  logic                       cfg_last,
  input  logic                       go,
  output logic                       busy,
  output logic                       done,
  output logic [WEIGHT_W+PART_W-1:0] wt_bus,
  output logic                       wt_load,
  output logic                       wt_valid,
  output logic                       l1_start,
  output logic                       l1_restart,
  output logic                       l1_shift,
  input  logic                       l1_finished,
  input  logic                       l1_transferred,
  input  logic                       l1_ready,
  input  logic [DATA_W-1:0]          l1_sout,
  output logic                       l2_start,
  output logic                       l2_restart,
  output logic                       l2_shift,
  output logic                       l2_in_valid,
  output logic [IN_W-1:0]            l2_in_data,
  input  logic                       l2_finished,
  input  logic                       l2_transferred,
  input  logic                       l2_ready,
  input  logic [DATA_W-1:0]          l2_sout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_W-1:0]          res_data,
  output logic                       res_last
);

  localparam int NMAX = (NN1 > NN2) ? NN1 : NN2;
  localparam int CW   = $clog2(NMAX + 1);
  localparam logic [CW-1:0] NN1_C = CW'(NN1);
  localparam logic [CW-1:0] NN2_C = CW'(NN2);

  logic [3:0]        state, state_nx;
  logic [1:0]        phase, phase_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [DATA_W-1:0] res_data_q;
  logic              res_last_q;
  logic              done_q;
  logic [IN_W-1:0]   sat_out;
  logic              run_active;

  // Drain length is counted locally, so layer 2's own transfer flag is not needed.
  logic unused_l2_transferred;
  assign unused_l2_transferred = l2_transferred;

  sat_narrow #(.DATA_W(DATA_W), .IN_W(IN_W)) u_sat (
    .din  (l1_sout),
    .dout (sat_out)
  );

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE:  if (cfg_valid) state_nx = ST_LOAD;
      ST_LOAD:  if (cfg_valid && cfg_last) state_nx = ST_LWAIT;
      ST_LWAIT: if (l1_ready && l2_ready) state_nx = ST_READY;
      ST_READY: begin
        if (cfg_valid) state_nx = ST_LOAD;
        else if (go)   state_nx = ST_RUN1;
      end
      ST_RUN1: begin
        if (l1_finished) begin
          state_nx = ST_XFER;
          phase_nx = PH_SHIFT;
          cnt_nx   = '0;
        end
      end
      ST_XFER: begin
        // Once all NN1 words are captured, stop shifting and wait for layer 1 to confirm.
        if (cnt == NN1_C) begin
          if (l1_transferred) state_nx = ST_RUN2;
        end else if (phase == PH_SHIFT) begin
          phase_nx = PH_CAPTURE;
        end else begin
          phase_nx = PH_SHIFT;
          cnt_nx   = cnt + 1'b1;
        end
      end
      ST_RUN2: begin
        if (l2_finished) begin
          state_nx = ST_DRAIN;
          phase_nx = PH_SHIFT;
          cnt_nx   = '0;
        end
      end
      ST_DRAIN: begin
        case (phase)
          PH_SHIFT:   phase_nx = PH_CAPTURE;
          PH_CAPTURE: begin
            phase_nx = PH_HOLD;
            cnt_nx   = cnt + 1'b1;
          end
          PH_HOLD: begin
            if (res_ready) begin
              if (res_last_q) state_nx = ST_RESTART;
              else            phase_nx = PH_SHIFT;
            end
          end
          default: phase_nx = PH_SHIFT;
        endcase
      end
      ST_RESTART: if (!l1_finished && !l2_finished) state_nx = ST_READY;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      phase      <= PH_SHIFT;
      cnt        <= '0;
      res_data_q <= '0;
      res_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      cnt    <= cnt_nx;
      done_q <= (state == ST_RESTART) && (state_nx == ST_READY);
      if (state == ST_DRAIN && phase == PH_CAPTURE) begin
        res_data_q <= l2_sout;
        res_last_q <= ((cnt + 1'b1) == NN2_C);
      end
    end
  end

  assign run_active  = (state == ST_RUN1) || (state == ST_XFER) || (state == ST_RUN2);

  assign cfg_ready   = (state == ST_LOAD);
  assign wt_load     = (state == ST_LOAD);
  assign wt_valid    = (state == ST_LOAD) && cfg_valid;
  assign wt_bus      = (state == ST_LOAD) ? cfg_word : '0;
  assign busy        = (state != ST_IDLE) && (state != ST_READY);
  assign done        = done_q;

  assign l1_start    = run_active;
  assign l2_start    = run_active;
  assign l1_restart  = (state == ST_RESTART);
  assign l2_restart  = (state == ST_RESTART);
  assign l1_shift    = (state == ST_XFER) && (phase == PH_SHIFT) && (cnt != NN1_C);
  assign l2_in_valid = (state == ST_XFER) && (phase == PH_CAPTURE) && (cnt != NN1_C);
  assign l2_in_data  = l2_in_valid ? sat_out : '0;
  assign l2_shift    = (state == ST_DRAIN) && (phase == PH_SHIFT);

  assign res_valid   = (state == ST_DRAIN) && (phase == PH_HOLD);
  assign res_data    = res_data_q;
  assign res_last    = res_valid && res_last_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with behavioural layer-1/layer-2 models and a stalling result consumer.
module tb_layer_sequencer;

  localparam int NN1    = 30;
  localparam int NN2    = 10;
  localparam int IN_W   = 26;
  localparam int DATA_W = 29;
  localparam int CFG_W  = 22;
  localparam int OUT_W  = 3 + CFG_W + 2 + 3 + 4 + IN_W + 1 + DATA_W + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cfg_valid = 1'b0, cfg_last = 1'b0, go = 1'b0;
  logic [CFG_W-1:0]  cfg_word = '0;
  logic              cfg_ready, busy, done, wt_load, wt_valid;
  logic [CFG_W-1:0]  wt_bus;
  logic              l1_start, l1_restart, l1_shift;
  logic              l1_finished = 1'b0, l1_transferred = 1'b0, l1_ready = 1'b0;
  logic [DATA_W-1:0] l1_sout = '0;
  logic              l2_start, l2_restart, l2_shift, l2_in_valid;
  logic [IN_W-1:0]   l2_in_data;
  logic              l2_finished = 1'b0, l2_transferred = 1'b0, l2_ready = 1'b0;
  logic [DATA_W-1:0] l2_sout = '0;
  logic              res_valid, res_last;
  logic              res_ready = 1'b1;
  logic [DATA_W-1:0] res_data;
  logic [OUT_W-1:0]  outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_sequencer #(.NN1(NN1), .NN2(NN2)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_word(cfg_word), .cfg_last(cfg_last),
    .go(go), .busy(busy), .done(done),
    .wt_bus(wt_bus), .wt_load(wt_load), .wt_valid(wt_valid),
    .l1_start(l1_start), .l1_restart(l1_restart), .l1_shift(l1_shift),
    .l1_finished(l1_finished), .l1_transferred(l1_transferred), .l1_ready(l1_ready), .l1_sout(l1_sout),
    .l2_start(l2_start), .l2_restart(l2_restart), .l2_shift(l2_shift),
    .l2_in_valid(l2_in_valid), .l2_in_data(l2_in_data),
    .l2_finished(l2_finished), .l2_transferred(l2_transferred), .l2_ready(l2_ready), .l2_sout(l2_sout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  assign outs = {cfg_ready, busy, done, wt_bus, wt_load, wt_valid,
                 l1_start, l1_restart, l1_shift,
                 l2_start, l2_restart, l2_shift, l2_in_valid, l2_in_data,
                 res_valid, res_data, res_last};

  // Layer models: sample at negedge, respond before the next posedge.
  int l1_cnt = 0, l1_word = 0, l2_cnt = 0, l2_rx = 0, l2_word = 0;
  bit sat_mode = 1'b0;

  function automatic logic [DATA_W-1:0] l1_value(int k);
    if (sat_mode && k == 1) return 29'h0FFFFFFF;
    if (sat_mode && k == 2) return 29'h10000000;
    return DATA_W'(k);
  endfunction

  always @(negedge clk) begin
    if (!rstn || l1_restart) begin
      l1_finished = 1'b0; l1_transferred = 1'b0; l1_sout = '0; l1_cnt = 0; l1_word = 0;
    end else begin
      if (l1_start && !l1_finished) begin
        l1_cnt++;
        if (l1_cnt == 3) l1_finished = 1'b1;
      end
      if (l1_shift) begin
        l1_word++;
        l1_sout = l1_value(l1_word);
        l1_transferred = (l1_word == NN1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn || l2_restart) begin
      l2_finished = 1'b0; l2_transferred = 1'b0; l2_sout = '0; l2_cnt = 0; l2_rx = 0; l2_word = 0;
    end else begin
      if (l2_in_valid) l2_rx++;
      if (l2_start && l2_rx == NN1 && !l2_finished) begin
        l2_cnt++;
        if (l2_cnt == 2) l2_finished = 1'b1;
      end
      if (l2_shift) begin
        l2_word++;
        l2_sout = DATA_W'(100 + l2_word);
        l2_transferred = (l2_word == NN2);
      end
    end
  end

  // Observation and result consumer; stalls word 3 for stall_left cycles.
  logic [IN_W-1:0]   cap_q[$];
  logic [DATA_W-1:0] res_q[$];
  logic              last_q[$];
  logic [DATA_W-1:0] stall_q[$];
  int wt_valid_cnt = 0, l1_start_rises = 0, done_cnt = 0, stall_left = 0;
  logic l1_start_prev = 1'b0;

  always @(negedge clk) begin
    if (wt_valid) wt_valid_cnt++;
    if (l1_start && !l1_start_prev) l1_start_rises++;
    l1_start_prev = l1_start;
    if (done) done_cnt++;
    if (l2_in_valid) cap_q.push_back(l2_in_data);
    if (res_valid) begin
      if (res_q.size() == 2 && stall_left > 0) begin
        res_ready = 1'b0;
        stall_q.push_back(res_data);
        stall_left--;
      end else begin
        res_ready = 1'b1;
        res_q.push_back(res_data);
        last_q.push_back(res_last);
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0; cfg_valid = 1'b1; cfg_word = 22'h3ABCD; go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    cfg_valid = 1'b0; go = 1'b0; rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL reset_idle: busy=%b cfg_ready=%b expected 0 0", busy, cfg_ready);
    end
  endtask

  task automatic test_load();
    int n;
    logic [CFG_W-1:0] w;
    wt_valid_cnt = 0; l1_start_rises = 0;
    go = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i % 7 == 3) begin
        cfg_valid = 1'b0;
        @(posedge clk); #1;
      end
      w = CFG_W'(i * 1237 + 5);
      cfg_word = w; cfg_valid = 1'b1; cfg_last = (i == 39);
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (cfg_ready !== 1'b1 || wt_bus !== w || wt_valid !== 1'b1 || wt_load !== 1'b1) begin
        failures++;
        $display("FAIL load_word%0d: rdy=%b bus=%h vld=%b load=%b expected 1 %h 1 1",
                 i, cfg_ready, wt_bus, wt_valid, wt_load, w);
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0; go = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++; $display("FAIL lwait: busy=%b cfg_ready=%b expected 1 0", busy, cfg_ready);
    end
    l1_ready = 1'b1; l2_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL ready_reached: busy=%b expected 0", busy);
    end
    checks++;
    if (wt_valid_cnt != 40) begin
      failures++; $display("FAIL wt_valid_count: got %0d expected 40", wt_valid_cnt);
    end
    checks++;
    if (l1_start_rises != 0) begin
      failures++; $display("FAIL go_in_load: l1_start rises %0d expected 0", l1_start_rises);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (done_cnt == 0) begin
      failures++; $display("FAIL %s_timeout: done not seen in %0d cycles", name, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_run();
    int bad;
    cap_q.delete(); res_q.delete(); last_q.delete(); stall_q.delete();
    stall_left = 5; done_cnt = 0; l1_start_rises = 0; sat_mode = 1'b0;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (l1_start !== 1'b1 || l2_start !== 1'b1) begin
      failures++; $display("FAIL run1_start: l1=%b l2=%b expected 1 1", l1_start, l2_start);
    end
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done("run");
    checks++;
    if (cap_q.size() != NN1) begin
      failures++; $display("FAIL xfer_count: got %0d expected %0d", cap_q.size(), NN1);
    end
    bad = 0;
    foreach (cap_q[k]) if (cap_q[k] !== IN_W'(k + 1)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL xfer_data: %0d words out of order, expected 0", bad);
    end
    checks++;
    if (res_q.size() != NN2) begin
      failures++; $display("FAIL res_count: got %0d expected %0d", res_q.size(), NN2);
    end
    bad = 0;
    foreach (res_q[k]) if (res_q[k] !== DATA_W'(101 + k) || last_q[k] !== (k == NN2 - 1)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL res_data_last: %0d bad words, expected 0", bad);
    end
    bad = 0;
    foreach (stall_q[k]) if (stall_q[k] !== DATA_W'(103)) bad++;
    checks++;
    if (stall_q.size() != 5 || bad != 0) begin
      failures++; $display("FAIL stall_hold: cycles=%0d bad=%0d expected 5 0", stall_q.size(), bad);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL done_pulse: got %0d expected 1", done_cnt);
    end
    checks++;
    if (l1_start_rises != 1) begin
      failures++; $display("FAIL go_in_run1: l1_start rises %0d expected 1", l1_start_rises);
    end
    checks++;
    if (busy !== 1'b0 || l1_start !== 1'b0) begin
      failures++; $display("FAIL back_to_ready: busy=%b l1_start=%b expected 0 0", busy, l1_start);
    end
  endtask

  task automatic test_saturation();
    cap_q.delete(); res_q.delete(); last_q.delete(); stall_q.delete();
    stall_left = 0; done_cnt = 0; sat_mode = 1'b1;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done("sat");
    checks++;
    if (cap_q.size() < 3 || cap_q[0] !== 26'h1FFFFFF) begin
      failures++; $display("FAIL sat_max: got %h expected 1ffffff", (cap_q.size() > 0) ? cap_q[0] : '0);
    end
    checks++;
    if (cap_q.size() < 3 || cap_q[1] !== 26'h2000000) begin
      failures++; $display("FAIL sat_min: got %h expected 2000000", (cap_q.size() > 1) ? cap_q[1] : '0);
    end
    checks++;
    if (cap_q.size() < 3 || cap_q[2] !== 26'h0000003) begin
      failures++; $display("FAIL sat_pass: got %h expected 3", (cap_q.size() > 2) ? cap_q[2] : '0);
    end
    sat_mode = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    int n;
    cap_q.delete();
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    n = 0;
    while (cap_q.size() < 7 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (cap_q.size() != 7 || busy !== 1'b1) begin
      failures++; $display("FAIL reach_word7: words=%0d busy=%b expected 7 1", cap_q.size(), busy);
    end
    #1;
    cfg_valid = 1'b1; cfg_word = 22'h2AAAA; rstn = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL midrun_reset_now: got %h expected 0", outs);
    end
    @(posedge clk); #1;
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL midrun_reset_next: got %h expected 0", outs);
    end
    cfg_valid = 1'b0; rstn = 1'b1;
    go = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || l1_start !== 1'b0) begin
      failures++; $display("FAIL weights_lost: busy=%b l1_start=%b expected 0 0", busy, l1_start);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_saturation();
    test_reset_mid_xfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
